spi_reg_ctrl: RTL and testbench

//  Frame decoder and register-write sequencer between the SPI shift front end and the PWM/output logic.

---
 rtl/spi_reg_pkg.sv | 31 +++
 rtl/spi_sync_timer.sv | 34 +++
 rtl/spi_reg_ctrl.sv | 169 ++++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register-write controller.
// State encoding, register addresses and 16-bit frame field positions.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHECK     = 2'd1,
        WAIT_SYNC = 2'd2,
        COMMIT    = 2'd3
    } state_t;

    localparam logic [6:0] ADDR_OUT_LO = 7'd0;
    localparam logic [6:0] ADDR_OUT_HI = 7'd1;
    localparam logic [6:0] ADDR_PWM_LO = 7'd2;
    localparam logic [6:0] ADDR_PWM_HI = 7'd3;
    localparam logic [6:0] ADDR_DUTY   = 7'd4;

    localparam int         FRAME_BITS   = 16;
    localparam logic [4:0] FRAME_BITS_V = 5'd16;
    localparam int         RW_BIT       = 15;
    localparam int         ADDR_MSB     = 14;
    localparam int         ADDR_LSB     = 8;
    localparam int         DATA_MSB     = 7;
    localparam int         DATA_LSB     = 0;

    typedef struct packed {
        logic [FRAME_BITS-1:0] data;
        logic [4:0]            bits;
    } frame_t;

endpackage

// File: rtl/spi_sync_timer.sv
// Wait counter for period-synchronised duty writes; expire flags the
// last cycle before a duty write is force-committed.
module spi_sync_timer #(
    parameter int SYNC_TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = (SYNC_TIMEOUT > 1) ? $clog2(SYNC_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYNC_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] count_r;

    assign expire = (count_r == CNT_LAST);

    // Counter: cleared on request, advances while enabled, parks at the last value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (en && !expire) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/spi_reg_ctrl.sv
// Frame decoder and register-write sequencer; duty writes wait for a PWM period boundary.
// Optional error counter output err_count when SPI_REG_CTRL_ERR_CNT_EN is defined.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int MAX_ADDR     = 4,
    parameter int SYNC_TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_valid,
    input  logic [15:0] frame_data,
    input  logic [4:0]  frame_bits,
    input  logic        pwm_period_end,
    output logic [7:0]  en_reg_out_7_0,
    output logic [7:0]  en_reg_out_15_8,
    output logic [7:0]  en_reg_pwm_7_0,
    output logic [7:0]  en_reg_pwm_15_8,
    output logic [7:0]  pwm_duty_cycle,
    output logic        busy,
    output logic        wr_pulse,
    output logic        err_pulse
`ifdef SPI_REG_CTRL_ERR_CNT_EN
    ,
    output logic [7:0]  err_count
`endif
);

    localparam logic [6:0] MAX_ADDR_V = 7'(MAX_ADDR);

    state_t     state_r, state_s;
    frame_t     frame_q_r;
    logic       rw_s;
    logic [6:0] addr_s;
    logic [7:0] data_s;
    logic       check_err_s, overrun_s, err_set_s;
    logic       sync_clr_s, sync_en_s, sync_expire_s;

    assign rw_s      = frame_q_r.data[RW_BIT];
    assign addr_s    = frame_q_r.data[ADDR_MSB:ADDR_LSB];
    assign data_s    = frame_q_r.data[DATA_MSB:DATA_LSB];
    assign busy      = (state_r != IDLE);
    assign err_set_s = check_err_s | overrun_s;

    spi_sync_timer #(
        .SYNC_TIMEOUT (SYNC_TIMEOUT)
    ) u_sync_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (sync_clr_s),
        .en     (sync_en_s),
        .expire (sync_expire_s)
    );

    // Next-state decode and frame validation
    always_comb begin
        state_s     = state_r;
        check_err_s = 1'b0;
        sync_clr_s  = 1'b0;
        sync_en_s   = 1'b0;
        overrun_s   = frame_valid && (state_r != IDLE);
        case (state_r)
            IDLE: begin
                if (frame_valid) begin
                    state_s = CHECK;
                end else begin
                    state_s = IDLE;
                end
            end
            CHECK: begin
                sync_clr_s = 1'b1;
                if (frame_q_r.bits != FRAME_BITS_V) begin
                    check_err_s = 1'b1;
                    state_s     = IDLE;
                end else if (!rw_s) begin
                    state_s = IDLE;
                end else if (addr_s > MAX_ADDR_V) begin
                    check_err_s = 1'b1;
                    state_s     = IDLE;
                end else if (addr_s == ADDR_DUTY) begin
                    state_s = WAIT_SYNC;
                end else begin
                    state_s = COMMIT;
                end
            end
            WAIT_SYNC: begin
                sync_en_s = 1'b1;
                if (pwm_period_end || sync_expire_s) begin
                    state_s = COMMIT;
                end else begin
                    state_s = WAIT_SYNC;
                end
            end
            COMMIT: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Frame capture; only an idle controller accepts a new frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q_r <= '{data: 16'h0000, bits: 5'd0};
        end else if ((state_r == IDLE) && frame_valid) begin
            frame_q_r <= '{data: frame_data, bits: frame_bits};
        end else begin
            frame_q_r <= frame_q_r;
        end
    end

    // Configuration register file, written only from COMMIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_reg_out_7_0  <= 8'h00;
            en_reg_out_15_8 <= 8'h00;
            en_reg_pwm_7_0  <= 8'h00;
            en_reg_pwm_15_8 <= 8'h00;
            pwm_duty_cycle  <= 8'h00;
        end else if (state_r == COMMIT) begin
            case (addr_s)
                ADDR_OUT_LO: en_reg_out_7_0  <= data_s;
                ADDR_OUT_HI: en_reg_out_15_8 <= data_s;
                ADDR_PWM_LO: en_reg_pwm_7_0  <= data_s;
                ADDR_PWM_HI: en_reg_pwm_15_8 <= data_s;
                ADDR_DUTY:   pwm_duty_cycle  <= data_s;
                default:     pwm_duty_cycle  <= pwm_duty_cycle;
            endcase
        end else begin
            pwm_duty_cycle <= pwm_duty_cycle;
        end
    end

    // Status pulses; an overrun may coincide with a commit and both assert
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_pulse  <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            wr_pulse  <= (state_r == COMMIT);
            err_pulse <= err_set_s;
        end
    end

`ifdef SPI_REG_CTRL_ERR_CNT_EN
    // Saturating count of rejected frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= 8'h00;
        end else if (err_set_s && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'h01;
        end else begin
            err_count <= err_count;
        end
    end
`endif

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: a frame-level reference model queues expected
// write/error events and a monitor compares them whenever the DUT pulses.
module tb_spi_reg_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_valid = 1'b0;
    logic [15:0] frame_data = 16'h0000;
    logic [4:0]  frame_bits = 5'd0;
    logic        pwm_period_end = 1'b0;
    logic [7:0]  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
    logic        busy, wr_pulse, err_pulse;
`ifdef SPI_REG_CTRL_ERR_CNT_EN
    logic [7:0]  err_count;
`endif

    spi_reg_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_valid     (frame_valid),
        .frame_data      (frame_data),
        .frame_bits      (frame_bits),
        .pwm_period_end  (pwm_period_end),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .busy            (busy),
        .wr_pulse        (wr_pulse),
        .err_pulse       (err_pulse)
`ifdef SPI_REG_CTRL_ERR_CNT_EN
        ,
        .err_count       (err_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic        err;
        logic [39:0] regs;
    } ev_t;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] m_reg [5];
    int         m_errs = 0;
    logic       pend = 1'b0;
    logic [7:0] pend_data = 8'h00;
    ev_t        exp_q [$];
    ev_t        mon_e;

    wire [39:0] dut_regs = {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0,
                            en_reg_out_15_8, en_reg_out_7_0};

    function automatic logic [39:0] model_regs();
        return {m_reg[4], m_reg[3], m_reg[2], m_reg[1], m_reg[0]};
    endfunction

    // 0 = ignored read, 1 = rejected, 2 = immediate write, 3 = duty write
    function automatic int classify(input logic [15:0] d, input logic [4:0] b);
        if (b != 5'd16) return 1;
        if (!d[15]) return 0;
        if (d[14:8] > 7'd4) return 1;
        if (d[14:8] == 7'd4) return 3;
        return 2;
    endfunction

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic wr, input logic err);
        ev_t e;
        e.wr   = wr;
        e.err  = err;
        e.regs = model_regs();
        exp_q.push_back(e);
        if (err && m_errs < 255) m_errs++;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] d, input logic [4:0] b);
        frame_valid = 1'b1;
        frame_data  = d;
        frame_bits  = b;
        tick();
        frame_valid = 1'b0;
    endtask

    task automatic send(input logic [15:0] d, input logic [4:0] b);
        int k;
        k = classify(d, b);
        if (k == 1) begin
            push(1'b0, 1'b1);
        end else if (k == 2) begin
            m_reg[int'(d[14:8])] = d[7:0];
            push(1'b1, 1'b0);
        end else if (k == 3) begin
            pend      = 1'b1;
            pend_data = d[7:0];
        end
        drive(d, b);
    endtask

    task automatic period_pulse();
        if (pend) begin
            m_reg[4] = pend_data;
            pend     = 1'b0;
            push(1'b1, 1'b0);
        end
        pwm_period_end = 1'b1;
        tick();
        pwm_period_end = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input string name);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < limit) begin
            tick();
            n++;
        end
        check(name, {39'd0, (!busy && exp_q.size() == 0)}, 40'd1);
        exp_q.delete();
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;
        pend   = 1'b0;
        m_errs = 0;
        exp_q.delete();
    endtask

    // Monitor: every DUT pulse must match the oldest expected event
    always @(negedge clk) begin
        if (rst_n && (wr_pulse || err_pulse)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {38'd0, wr_pulse, err_pulse}, 40'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_kind", {38'd0, wr_pulse, err_pulse}, {38'd0, mon_e.wr, mon_e.err});
                check("pulse_regs", dut_regs, mon_e.regs);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int errs_before;
        logic [15:0] d;
        logic [4:0]  b;
        model_reset();
        repeat (3) tick();
        check("reset_regs", dut_regs, 40'd0);
        check("reset_busy", {39'd0, busy}, 40'd0);
        check("reset_pulses", {38'd0, wr_pulse, err_pulse}, 40'd0);
`ifdef SPI_REG_CTRL_ERR_CNT_EN
        check("reset_err_count", {32'd0, err_count}, 40'd0);
`endif
        rst_n = 1'b1;
        tick();

        // addr 0 write: visible after E+2, one-cycle wr_pulse, next frame at E+3
        send(16'h80F0, 5'd16);
        tick();
        check("t1_not_yet", {32'd0, en_reg_out_7_0}, {32'd0, 8'h00});
        tick();
        check("t1_visible", {32'd0, en_reg_out_7_0}, {32'd0, 8'hF0});
        check("t1_wr_pulse", {38'd0, wr_pulse, err_pulse}, {38'd0, 2'b10});
        check("t1_idle", {39'd0, busy}, 40'd0);
        send(16'h8155, 5'd16);
        check("t1_wr_one_cycle", {39'd0, wr_pulse}, 40'd0);
        wait_idle(10, "t1_back_to_back");
        check("t1_hi_reg", {32'd0, en_reg_out_15_8}, {32'd0, 8'h55});

        // duty write waits for the period boundary
        send(16'h8480, 5'd16);
        repeat (10) tick();
        check("t2_duty_held", {32'd0, pwm_duty_cycle}, 40'd0);
        check("t2_busy_wait", {39'd0, busy}, 40'd1);
        period_pulse();
        wait_idle(10, "t2_sync_commit");
        check("t2_duty", {32'd0, pwm_duty_cycle}, {32'd0, 8'h80});

        // forced commit: 4096 cycles in WAIT_SYNC, then COMMIT
        m_reg[4] = 8'hAA;
        push(1'b1, 1'b0);
        frame_valid = 1'b1;
        frame_data  = 16'h84AA;
        frame_bits  = 5'd16;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) frame_valid = 1'b0;
            if (n == 4000) check("t2_forced_held", {32'd0, pwm_duty_cycle}, {32'd0, 8'h80});
        end while (!wr_pulse && n < 5000);
        check("t2_forced_latency", 40'(n), 40'd4099);
        wait_idle(10, "t2_forced_idle");

        // rejected frames: bad address, bad length
        send(16'h8555, 5'd16);
        wait_idle(10, "t3_addr");
        send(16'h8022, 5'd15);
        wait_idle(10, "t3_len");
        check("t3_regs", dut_regs, model_regs());

        // read frame: ignored, busy only briefly
        send(16'h0012, 5'd16);
        check("t4_busy", {39'd0, busy}, 40'd1);
        tick();
        tick();
        check("t4_not_busy", {39'd0, busy}, 40'd0);
        wait_idle(10, "t4_idle");

        // overrun during WAIT_SYNC: second frame dropped, duty still commits
        errs_before = m_errs;
        send(16'h84C3, 5'd16);
        repeat (3) tick();
        push(1'b0, 1'b1);
        drive(16'h8011, 5'd16);
        repeat (2) tick();
`ifdef SPI_REG_CTRL_ERR_CNT_EN
        check("t5_err_count", {32'd0, err_count}, 40'(errs_before + 1));
`endif
        period_pulse();
        wait_idle(10, "t5_idle");
        check("t5_duty", {32'd0, pwm_duty_cycle}, {32'd0, 8'hC3});
        check("t5_dropped", {32'd0, en_reg_out_7_0}, {32'd0, m_reg[0]});

        // overrun sampled in COMMIT: wr_pulse and err_pulse together
        m_reg[2] = 8'h33;
        push(1'b1, 1'b1);
        drive(16'h8233, 5'd16);
        tick();
        drive(16'h8199, 5'd16);
        wait_idle(10, "t5_simul");

        // randomized frames against the model
        for (int i = 0; i < 40; i++) begin
            d = 16'($urandom);
            d[14:8] = 7'($urandom_range(0, 7));
            d[15] = ($urandom_range(0, 3) != 0);
            b = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : 5'd16;
            send(d, b);
            if (pend) begin
                repeat ($urandom_range(1, 30)) tick();
                period_pulse();
            end
            wait_idle(20, "rand_idle");
            if ($urandom_range(0, 2) == 0) period_pulse();
        end
        check("rand_regs", dut_regs, model_regs());
`ifdef SPI_REG_CTRL_ERR_CNT_EN
        check("rand_err_count", {32'd0, err_count}, 40'(m_errs));
`endif

        // reset while waiting for sync: pending write discarded
        send(16'h8477, 5'd16);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check("t6_reset_regs", dut_regs, 40'd0);
        check("t6_reset_busy", {39'd0, busy}, 40'd0);
        check("t6_reset_pulses", {38'd0, wr_pulse, err_pulse}, 40'd0);
        model_reset();
        tick();
        rst_n = 1'b1;
        tick();
        period_pulse();
        repeat (5) tick();
        check("t6_no_write", {32'd0, pwm_duty_cycle}, 40'd0);
        check("t6_idle", {39'd0, busy}, 40'd0);
`ifdef SPI_REG_CTRL_ERR_CNT_EN
        check("t6_err_count", {32'd0, err_count}, 40'd0);
`endif
        check("queue_drained", 40'(exp_q.size()), 40'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
